// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types and constants for the SPI RAM controller.
// Word width follows the SPI_RAM_PARITY_EN macro: 9 bits (data + even parity)
// when defined, 8 bits otherwise.
package spi_ram_pkg;

    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_ADDR_SIZE = 8;
    localparam int DATA_WIDTH    = 8;

`ifdef SPI_RAM_PARITY_EN
    localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int MEM_WIDTH = DATA_WIDTH;
`endif

    // Command field carried in rx_data[9:8]
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RD_ARMED = 2'b01,
        RD_RESP  = 2'b10
    } state_e;

    // Even parity bit: makes the total count of ones in {parity, data} even
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port word storage with synchronous write and a
// registered read port. Array contents survive reset; only the read
// register is cleared so the returned data starts from a known value.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WIDTH     = MEM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [MEM_DEPTH];

    // Array write; deliberately no reset so contents persist across rst_n
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; holds its value between reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder between an SPI slave and a small RAM.
// Write path: WR_ADDR latches a write pointer, WR_DATA stores and advances it.
// Read path: RD_ADDR arms a read pointer, RD_DATA returns one word one cycle
// later on tx_valid/tx_data and advances the pointer.
// Optional macro SPI_RAM_PARITY_EN adds a stored even-parity bit per word,
// err_inject corruption on writes, and par_err reporting on reads.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | no read address loaded; RD_DATA is out of sequence
// RD_ARMED | read address loaded, waiting for RD_DATA
// RD_RESP  | read word on tx_data, tx_valid high for this cycle
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [9:0] rx_data,
    input  logic       err_inject,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       seq_err,
    output logic       par_err
);

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   wr_addr, rd_addr;
    logic                   wr_addr_vld;
    logic                   seq_err_d;
    logic                   wr_addr_ld, wr_addr_inc;
    logic                   rd_addr_ld, rd_addr_inc;
    logic                   mem_we, mem_re;
    logic [ADDR_SIZE-1:0]   mem_addr;
    logic [MEM_WIDTH-1:0]   mem_wdata, mem_rdata;
    cmd_e                   cmd;
    logic [ADDR_SIZE-1:0]   rx_addr;

    assign cmd     = cmd_e'(rx_data[9:8]);
    assign rx_addr = ADDR_SIZE'(rx_data[7:0]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command decode: next state, memory strobes, pointer updates, seq_err
    always_comb begin
        state_d     = (state_q == RD_RESP) ? RD_ARMED : state_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        seq_err_d   = 1'b0;
        wr_addr_ld  = 1'b0;
        wr_addr_inc = 1'b0;
        rd_addr_ld  = 1'b0;
        rd_addr_inc = 1'b0;
        if (rx_valid) begin
            case (cmd)
                WR_ADDR: begin
                    wr_addr_ld = 1'b1;
                end
                WR_DATA: begin
                    if (wr_addr_vld) begin
                        mem_we      = 1'b1;
                        wr_addr_inc = 1'b1;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                RD_ADDR: begin
                    rd_addr_ld = 1'b1;
                    state_d    = RD_ARMED;
                end
                RD_DATA: begin
                    if (state_q == IDLE) begin
                        seq_err_d = 1'b1;
                    end else begin
                        mem_re      = 1'b1;
                        rd_addr_inc = 1'b1;
                        state_d     = RD_RESP;
                    end
                end
                default: begin
                    seq_err_d = 1'b0;
                end
            endcase
        end
    end

    // Write pointer and its valid flag; increment wraps at MEM_DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            wr_addr_vld <= 1'b0;
        end else if (wr_addr_ld) begin
            wr_addr     <= rx_addr;
            wr_addr_vld <= 1'b1;
        end else if (wr_addr_inc) begin
            wr_addr <= wr_addr + ADDR_SIZE'(1);
        end
    end

    // Read pointer; post-increments on every accepted RD_DATA
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr <= '0;
        end else if (rd_addr_ld) begin
            rd_addr <= rx_addr;
        end else if (rd_addr_inc) begin
            rd_addr <= rd_addr + ADDR_SIZE'(1);
        end
    end

    // Registered sequence-error pulse, one cycle per offending command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_err <= 1'b0;
        end else begin
            seq_err <= seq_err_d;
        end
    end

    // Only one command per cycle, so a write and a read never share the port
    assign mem_addr = mem_we ? wr_addr : rd_addr;

`ifdef SPI_RAM_PARITY_EN
    assign mem_wdata = {even_parity(rx_data[7:0]) ^ err_inject, rx_data[7:0]};
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign mem_wdata         = rx_data[7:0];
`endif

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE),
        .WIDTH     (MEM_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // The read register holds between reads, so tx_data needs no extra flop
    assign tx_valid = (state_q == RD_RESP);
    assign tx_data  = mem_rdata[7:0];

`ifdef SPI_RAM_PARITY_EN
    assign par_err = tx_valid & (^mem_rdata);
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed-vector bench for spi_ram_ctrl. Inputs change on
// the falling edge; outputs are sampled on the falling edge after the
// accepting rising edge.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       err_inject;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       seq_err;
    logic       par_err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [1:0] C_WA = 2'b00;
    localparam logic [1:0] C_WD = 2'b01;
    localparam logic [1:0] C_RA = 2'b10;
    localparam logic [1:0] C_RD = 2'b11;

    always #5 clk = ~clk;

    spi_ram_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .err_inject (err_inject),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .seq_err    (seq_err),
        .par_err    (par_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command accepted on the next rising edge; returns at the falling
    // edge of the cycle that follows acceptance
    task automatic send(input logic [1:0] c, input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = {c, d};
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        err_inject = 1'b0;
        idle(2);

        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data",  tx_data,  8'h00);
        chk("rst_seq_err",  seq_err,  1'b0);
        chk("rst_par_err",  par_err,  1'b0);
        rst_n = 1'b1;
        idle(1);

        // RD_DATA straight after reset is out of sequence
        send(C_RD, 8'h00);
        chk("seq_rd_pulse", seq_err,  1'b1);
        chk("seq_rd_txv",   tx_valid, 1'b0);
        idle(1);
        chk("seq_rd_clear", seq_err,  1'b0);

        // Seed a word, reset, then an orphan WR_DATA must not disturb it
        send(C_WA, 8'h05);
        send(C_WD, 8'h77);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        send(C_WD, 8'h99);
        chk("seq_wd_pulse", seq_err, 1'b1);
        send(C_RA, 8'h05);
        chk("seq_wd_clear", seq_err, 1'b0);
        send(C_RD, 8'h00);
        chk("keep_txv",  tx_valid, 1'b1);
        chk("keep_data", tx_data,  8'h77);

        // Basic write/read
        send(C_WA, 8'h10);
        send(C_WD, 8'hA5);
        send(C_RA, 8'h10);
        chk("basic_pre_txv", tx_valid, 1'b0);
        send(C_RD, 8'h00);
        chk("basic_txv",  tx_valid, 1'b1);
        chk("basic_data", tx_data,  8'hA5);
        chk("basic_par",  par_err,  1'b0);
        idle(1);
        chk("hold_txv",  tx_valid, 1'b0);
        chk("hold_data", tx_data,  8'hA5);

        // rx_data with rx_valid low is ignored
        rx_data = {C_RD, 8'h00};
        idle(1);
        chk("ignore_txv", tx_valid, 1'b0);

        // Address wrap with back-to-back reads
        send(C_WA, 8'hFF);
        send(C_WD, 8'h11);
        send(C_WD, 8'h22);
        send(C_RA, 8'hFF);
        send(C_RD, 8'h00);
        chk("wrap_txv0",  tx_valid, 1'b1);
        chk("wrap_data0", tx_data,  8'h11);
        send(C_RD, 8'h00);
        chk("wrap_txv1",  tx_valid, 1'b1);
        chk("wrap_data1", tx_data,  8'h22);

        // Read in the cycle right after a write to the same address
        send(C_RA, 8'h40);
        send(C_WA, 8'h40);
        send(C_WD, 8'h5A);
        send(C_RD, 8'h00);
        chk("raw_data", tx_data, 8'h5A);

        // RD_ADDR during RD_RESP: current response completes, new pointer used
        send(C_WA, 8'h20);
        send(C_WD, 8'hC3);
        send(C_WA, 8'h30);
        send(C_WD, 8'h3C);
        send(C_RA, 8'h20);
        send(C_RD, 8'h00);
        chk("reload_txv0",  tx_valid, 1'b1);
        chk("reload_data0", tx_data,  8'hC3);
        send(C_RA, 8'h30);
        chk("reload_gap", tx_valid, 1'b0);
        send(C_RD, 8'h00);
        chk("reload_data1", tx_data, 8'h3C);

        // Reset in the RD_RESP cycle drops the response
        rst_n = 1'b0;
        idle(1);
        chk("rstresp_txv",  tx_valid, 1'b0);
        chk("rstresp_data", tx_data,  8'h00);
        rst_n = 1'b1;
        send(C_RD, 8'h00);
        chk("rstresp_idle", seq_err,  1'b1);
        chk("rstresp_noq",  tx_valid, 1'b0);
        send(C_RA, 8'h10);
        send(C_RD, 8'h00);
        chk("rstresp_keep", tx_data, 8'hA5);

        // Parity injection
        err_inject = 1'b1;
        send(C_WA, 8'h50);
        send(C_WD, 8'h3C);
        err_inject = 1'b0;
        send(C_WD, 8'h3C);
        send(C_RA, 8'h50);
        send(C_RD, 8'h00);
        chk("par_inj_txv",  tx_valid, 1'b1);
        chk("par_inj_data", tx_data,  8'h3C);
`ifdef SPI_RAM_PARITY_EN
        chk("par_inj_err",  par_err,  1'b1);
`else
        chk("par_inj_err",  par_err,  1'b0);
`endif
        send(C_RD, 8'h00);
        chk("par_ok_data", tx_data, 8'h3C);
        chk("par_ok_err",  par_err, 1'b0);
        idle(1);
        chk("par_idle_err", par_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8, address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 clk  input  1  clock; all logic SHALL be rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx_valid  input  1  one-cycle strobe from SPI slave marking a valid rx_data word.
REQ-006 rx_data  input  10  bits [9:8] command, bits [7:0] address or data.
REQ-007 err_inject  input  1  parity-error injection on writes; used only with SPI_RAM_PARITY_EN.
REQ-008 tx_valid  output  1  one-cycle strobe marking valid read data.
REQ-009 tx_data  output  8  read data returned to the SPI slave.
REQ-010 seq_err  output  1  one-cycle pulse on an out-of-sequence command.
REQ-011 par_err  output  1  one-cycle pulse, coincident with tx_valid, on read parity mismatch.

Function
REQ-012 Commands SHALL be decoded only when rx_valid=1; rx_data SHALL be ignored otherwise.
REQ-013 Command 00 (WR_ADDR) SHALL latch wr_addr=rx_data[7:0] and set wr_addr_vld.
REQ-014 Command 01 (WR_DATA) with wr_addr_vld=1 SHALL write rx_data[7:0] to mem[wr_addr], then increment wr_addr modulo MEM_DEPTH (wraps 255->0).
REQ-015 Command 10 (RD_ADDR) SHALL latch rd_addr=rx_data[7:0] and move the FSM IDLE->RD_ARMED.
REQ-016 Command 11 (RD_DATA) in RD_ARMED SHALL read mem[rd_addr], move to RD_RESP, and increment rd_addr modulo MEM_DEPTH.
REQ-017 FSM states SHALL be IDLE, RD_ARMED and RD_RESP; RD_RESP SHALL last exactly one cycle, then return to RD_ARMED.
REQ-018 In RD_RESP, tx_valid SHALL be 1 and tx_data SHALL be the read word: one-cycle latency from the accepting rx_valid edge.
REQ-019 tx_data SHALL hold its last value until the next read response; tx_valid SHALL be 0 outside RD_RESP.
REQ-020 WR_DATA with wr_addr_vld=0 and RD_DATA in IDLE SHALL each pulse seq_err for one cycle and change no state, memory or output.
REQ-021 RD_ADDR in RD_ARMED or RD_RESP SHALL reload rd_addr and go to RD_ARMED; a response already in RD_RESP SHALL still complete.
REQ-022 A read in the cycle after a write to the same address SHALL return the newly written data.
REQ-023 rx_valid in RD_RESP SHALL be accepted normally; back-to-back RD_DATA SHALL produce back-to-back tx_valid pulses.

Reset
REQ-024 On rst_n=0: tx_valid=0, tx_data=0, seq_err=0, par_err=0, wr_addr=0, rd_addr=0, wr_addr_vld=0, FSM=IDLE.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 Reset during RD_RESP SHALL drop the pending response; tx_valid SHALL be 0 in the next cycle.

Configuration
REQ-027 Macro SPI_RAM_PARITY_EN defined: each word SHALL store 9 bits (data plus even parity), with the parity bit inverted when err_inject=1 during WR_DATA.
REQ-028 With SPI_RAM_PARITY_EN, every read SHALL check parity and pulse par_err with tx_valid on mismatch; tx_data SHALL still be driven.
REQ-029 Macro undefined: storage SHALL be 8 bits, err_inject SHALL be ignored, and par_err SHALL be tied 0.

Structure
REQ-030 Package spi_ram_pkg SHALL hold the command enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA), the FSM state enum, and default MEM_DEPTH/ADDR_SIZE constants.
REQ-031 Storage SHALL be a sub-module spi_ram_mem: single-port, synchronous write, registered read, width 8 or 9 by macro.

Verification
REQ-032 WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> tx_valid one cycle after RD_DATA with tx_data=0xA5.
REQ-033 WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, then read 0xFF twice consecutively -> tx_data 0x11, then 0x22 read back from address 0x00 (wrap).
REQ-034 After reset, RD_DATA -> seq_err=1 for one cycle, tx_valid stays 0; WR_DATA -> seq_err=1, memory unchanged.
REQ-035 rst_n=0 in RD_RESP cycle -> tx_valid=0 and tx_data=0 next cycle, FSM=IDLE, earlier written data still readable.
REQ-036 With SPI_RAM_PARITY_EN: write 0x3C with err_inject=1, read it back -> tx_data=0x3C, tx_valid=1 and par_err=1 in the same cycle; a normal write reads back with par_err=0.
